// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: per-master request/burst handshakes plus the shared SDRAM controller command port.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
);
  logic [2:0]          req, req_we, grant, wnext, rvalid, done;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LEN_W-1:0]  req_len;
  logic [3*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]   rdata, mem_wdata, mem_rdata;
  logic                mem_cmd_valid, mem_cmd_ready, mem_we, mem_wnext, mem_rvalid, mem_done;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LEN_W-1:0]    mem_len;
  modport slave (
    input  req, req_we, req_addr, req_len, req_wdata, mem_cmd_ready, mem_wnext, mem_rvalid, mem_rdata, mem_done,
    output grant, wnext, rvalid, rdata, done, mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata
  );
  modport master (
    output req, req_we, req_addr, req_len, req_wdata, mem_cmd_ready, mem_wnext, mem_rvalid, mem_rdata, mem_done,
    input  grant, wnext, rvalid, rdata, done, mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: port 0 fixed priority, ports 1/2 round-robin, owner holds the SDRAM port for a whole burst.
// Optional SDRAM_ARB_STARVE_EN lets a long-waiting port 1/2 pre-empt port 0 in IDLE.
module sdram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
`ifdef SDRAM_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = 255
`endif
) (
  input logic clk,
  input logic reset_n,
  sdram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, rr_last_q, rr_last_d, pick, rr_pick;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0] own_oh;
  // owner 3 means "none" and shifts out to an all-zero one-hot
  assign own_oh = 3'b001 << owner_q;
  assign rr_pick = (bus.req[1] && bus.req[2]) ? (rr_last_q == 2'd1 ? 2'd2 : 2'd1) : (bus.req[1] ? 2'd1 : 2'd2);
`ifdef SDRAM_ARB_STARVE_EN
  logic [7:0] wait1_q, wait1_d, wait2_q, wait2_d;
  logic st1, st2;
  assign st1 = bus.req[1] && int'(wait1_q) >= STARVE_LIMIT;
  assign st2 = bus.req[2] && int'(wait2_q) >= STARVE_LIMIT;
  assign pick = (st1 || st2) ? ((st1 && st2) ? (rr_last_q == 2'd1 ? 2'd2 : 2'd1) : (st1 ? 2'd1 : 2'd2))
                             : (bus.req[0] ? 2'd0 : rr_pick);
  assign wait1_d = bus.grant[1] ? 8'd0
                 : (bus.req[1] && !(state_q != IDLE && owner_q == 2'd1) && wait1_q != 8'hff) ? wait1_q + 8'd1 : wait1_q;
  assign wait2_d = bus.grant[2] ? 8'd0
                 : (bus.req[2] && !(state_q != IDLE && owner_q == 2'd2) && wait2_q != 8'hff) ? wait2_q + 8'd1 : wait2_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wait1_q <= '0;
      wait2_q <= '0;
    end else begin
      wait1_q <= wait1_d;
      wait2_q <= wait2_d;
    end
`else
  assign pick = bus.req[0] ? 2'd0 : rr_pick;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_last_d = rr_last_q;
    we_d = we_q;
    addr_d = addr_q;
    len_d = len_q;
    bus.grant = '0;
    bus.wnext = '0;
    bus.rvalid = '0;
    bus.done = '0;
    if (state_q == IDLE && |bus.req) begin
      owner_d = pick;
      we_d = bus.req_we[pick];
      addr_d = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
      len_d = bus.req_len[int'(pick)*LEN_W +: LEN_W];
      state_d = ISSUE;
    end
    if (state_q == ISSUE && bus.mem_cmd_ready) begin
      bus.grant = own_oh;
      state_d = BUSY;
    end
    if (state_q == BUSY) begin
      bus.wnext = bus.mem_wnext ? own_oh : 3'b000;
      bus.rvalid = bus.mem_rvalid ? own_oh : 3'b000;
      bus.done = bus.mem_done ? own_oh : 3'b000;
      if (bus.mem_done) begin
        state_d = IDLE;
        rr_last_d = owner_q == 2'd0 ? rr_last_q : owner_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      rr_last_q <= 2'd2;
      we_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_last_q <= rr_last_d;
      we_q <= we_d;
      addr_q <= addr_d;
      len_q <= len_d;
    end
  assign bus.mem_cmd_valid = state_q == ISSUE;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_len = len_q;
  assign bus.rdata = bus.mem_rdata;
  assign bus.mem_wdata = state_q == IDLE ? '0
                       : owner_q == 2'd0 ? bus.req_wdata[0 +: DATA_W]
                       : owner_q == 2'd1 ? bus.req_wdata[DATA_W +: DATA_W]
                       : bus.req_wdata[2*DATA_W +: DATA_W];
endmodule
